// File: rtl/utype_decode_stage_if.sv
// Fetch-to-execute bus of the U-type decode stage: instruction handshake in,
// decoded operand handshake out.
interface utype_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm20;
  logic [31:0] pc_out;
  logic [4:0]  rd;
  logic        IS_lui;
  logic        IS_Utype;

  modport master (
    output in_valid, inst, pc_in, out_ready,
    input  in_ready, out_valid, imm20, pc_out, rd, IS_lui, IS_Utype
  );

  modport slave (
    input  in_valid, inst, pc_in, out_ready,
    output in_ready, out_valid, imm20, pc_out, rd, IS_lui, IS_Utype
  );
endinterface

// File: rtl/utype_decode_stage.sv
// U-type decode/issue stage: decodes LUI/AUIPC operands and presents them to
// execute through an output register backed by a one-entry skid buffer.
module utype_decode_stage #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  utype_decode_stage_if.slave  bus,
  output logic [CNT_W-1:0]     utype_count
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] imm20;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        is_lui;
    logic        is_utype;
  } dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic dec_t decode(input logic [31:0] inst, input logic [31:0] pc);
    dec_t d;
    d.pc       = pc;
    d.is_lui   = (inst[6:0] == OP_LUI);
    d.is_utype = (inst[6:0] == OP_LUI) || (inst[6:0] == OP_AUIPC);
    d.imm20    = d.is_utype ? {inst[31:12], 12'h000} : 32'h0;
    d.rd       = d.is_utype ? inst[11:7] : 5'd0;
    return d;
  endfunction

  localparam dec_t DEC_RESET = '{imm20: 32'h0, pc: RESET_PC, rd: 5'd0,
                                 is_lui: 1'b0, is_utype: 1'b0};

  state_t     state;
  dec_t       dec_p0;
  dec_t       out_p1;
  dec_t       skid_p1;
  logic       vld_p1;
  logic       rdy_p1;
  logic       accept;
  logic       issue;

  // Stage 0: combinational decode of the presented instruction
  assign dec_p0 = decode(bus.inst, bus.pc_in);
  assign accept = bus.in_valid && rdy_p1;
  assign issue  = vld_p1 && bus.out_ready;

  // Stage 1: output register plus skid entry; in_ready is a pure function of occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_EMPTY;
      vld_p1      <= 1'b0;
      rdy_p1      <= 1'b1;
      out_p1      <= DEC_RESET;
      skid_p1     <= DEC_RESET;
      utype_count <= '0;
    end else begin
      if (issue && out_p1.is_utype)
        utype_count <= utype_count + 1'b1;
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_p1 <= dec_p0;
            vld_p1 <= 1'b1;
            state  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && issue) begin
            out_p1 <= dec_p0;
          end else if (accept) begin
            skid_p1 <= dec_p0;
            rdy_p1  <= 1'b0;
            state   <= ST_TWO;
          end else if (issue) begin
            vld_p1 <= 1'b0;
            state  <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (issue) begin
            out_p1 <= skid_p1;
            rdy_p1 <= 1'b1;
            state  <= ST_ONE;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          rdy_p1 <= 1'b1;
          state  <= ST_EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = rdy_p1;
  assign bus.out_valid = vld_p1;
  assign bus.imm20     = out_p1.imm20;
  assign bus.pc_out    = out_p1.pc;
  assign bus.rd        = out_p1.rd;
  assign bus.IS_lui    = out_p1.is_lui;
  assign bus.IS_Utype  = out_p1.is_utype;

endmodule

// File: tb/tb_utype_decode_stage.sv
// Randomised and directed bench for utype_decode_stage against a queue-based
// reference model of the decode/skid behaviour.
module tb_utype_decode_stage;

  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'hDEAD_0000;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        lui;
    logic        ut;
  } exp_t;

  logic             clk    = 1'b0;
  logic             clk_en = 1'b0;
  logic             rst    = 1'b0;
  logic [CNT_W-1:0] utype_count;

  utype_decode_stage_if bus();

  utype_decode_stage #(.CNT_W(CNT_W), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .utype_count (utype_count)
  );

  always #5 if (clk_en) clk = ~clk;

  exp_t q[$];
  exp_t last_m;
  int   cnt_m;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    int   op;
    op    = int'(i % 128);
    e.pc  = p;
    e.lui = (op == 'h37);
    e.ut  = (op == 'h37) || (op == 'h17);
    e.imm = e.ut ? (i & 32'hFFFF_F000) : 32'h0;
    e.rd  = e.ut ? 5'((i >> 7) % 32) : 5'd0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    cnt_m  = 0;
    last_m = '{imm: 32'h0, pc: RESET_PC, rd: 5'd0, lui: 1'b0, ut: 1'b0};
  endtask

  task automatic compare_all();
    exp_t e;
    e = (q.size() > 0) ? q[0] : last_m;
    chk("out_valid",   32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready",    32'(bus.in_ready),  32'(q.size() < 2));
    chk("utype_count", 32'(utype_count),   32'(cnt_m));
    chk("imm20",       bus.imm20,          e.imm);
    chk("pc_out",      bus.pc_out,         e.pc);
    chk("rd",          32'(bus.rd),        32'(e.rd));
    chk("IS_lui",      32'(bus.IS_lui),    32'(e.lui));
    chk("IS_Utype",    32'(bus.IS_Utype),  32'(e.ut));
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
  task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] p, input logic ordy);
    bit acc;
    bit iss;
    bus.in_valid  = v;
    bus.inst      = i;
    bus.pc_in     = p;
    bus.out_ready = ordy;
    acc = v && (q.size() < 2);
    iss = (q.size() > 0) && ordy;
    @(posedge clk);
    if (iss) begin
      if (q[0].ut) cnt_m = (cnt_m + 1) % (1 << CNT_W);
      void'(q.pop_front());
    end
    if (acc) q.push_back(model_decode(i, p));
    if (q.size() > 0) last_m = q[0];
    @(negedge clk);
    compare_all();
  endtask

  task automatic apply_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
    chk("rst_count",     32'(utype_count),   32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    logic [31:0] ri;
    logic [31:0] rp;
    int          sel;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.inst      = 32'h0;
    bus.pc_in     = 32'h0;

    // Reset with no clock running
    #1 rst = 1'b1;
    #2;
    chk("por_out_valid", 32'(bus.out_valid), 32'h0);
    chk("por_in_ready",  32'(bus.in_ready),  32'h1);
    chk("por_count",     32'(utype_count),   32'h0);
    chk("por_pc_out",    bus.pc_out,         RESET_PC);
    chk("por_imm20",     bus.imm20,          32'h0);
    model_reset();
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // LUI decode
    cycle(1'b1, 32'h123452B7, 32'h0000_0100, 1'b1);
    chk("lui_valid", 32'(bus.out_valid), 32'h1);
    chk("lui_imm",   bus.imm20,          32'h1234_5000);
    chk("lui_rd",    32'(bus.rd),        32'd5);
    chk("lui_islui", 32'(bus.IS_lui),    32'h1);
    chk("lui_isu",   32'(bus.IS_Utype),  32'h1);
    chk("lui_pc",    bus.pc_out,         32'h0000_0100);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("lui_count", 32'(utype_count),   32'h1);

    // AUIPC then addi back to back
    apply_reset();
    cycle(1'b1, 32'hFFFFF097, 32'h0000_1000, 1'b1);
    chk("auipc_imm",   bus.imm20,         32'hFFFF_F000);
    chk("auipc_rd",    32'(bus.rd),       32'd1);
    chk("auipc_islui", 32'(bus.IS_lui),   32'h0);
    chk("auipc_isu",   32'(bus.IS_Utype), 32'h1);
    cycle(1'b1, 32'h00100093, 32'h0000_1004, 1'b1);
    chk("addi_isu",  32'(bus.IS_Utype), 32'h0);
    chk("addi_imm",  bus.imm20,         32'h0);
    chk("addi_rd",   32'(bus.rd),       32'h0);
    chk("addi_pc",   bus.pc_out,        32'h0000_1004);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("addi_count", 32'(utype_count), 32'h1);

    // Back-pressure: three instructions against a stalled consumer
    cycle(1'b1, 32'h000010B7, 32'h0000_0200, 1'b0);
    cycle(1'b1, 32'h00002117, 32'h0000_0204, 1'b0);
    chk("bp_ready_drop", 32'(bus.in_ready), 32'h0);
    cycle(1'b1, 32'h00100093, 32'h0000_0208, 1'b0);
    chk("bp_hold_pc", bus.pc_out, 32'h0000_0200);
    cycle(1'b1, 32'h00100093, 32'h0000_0208, 1'b0);
    chk("bp_hold_imm", bus.imm20, 32'h0000_1000);
    cycle(1'b1, 32'h00100093, 32'h0000_0208, 1'b1);
    chk("bp_second_pc", bus.pc_out, 32'h0000_0204);
    cycle(1'b1, 32'h00100093, 32'h0000_0208, 1'b1);
    chk("bp_third_pc", bus.pc_out, 32'h0000_0208);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("bp_drained", 32'(bus.out_valid), 32'h0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      ri  = $urandom;
      rp  = $urandom;
      sel = $urandom_range(0, 2);
      if (sel == 0) ri[6:0] = 7'b0110111;
      else if (sel == 1) ri[6:0] = 7'b0010111;
      cycle(1'($urandom_range(0, 1)), ri, rp, 1'($urandom_range(0, 3) != 0));
    end

    // Counter wrap with a 4-bit counter
    apply_reset();
    for (int n = 0; n < 17; n++)
      cycle(1'b1, 32'hABCDE037 | (32'(n) << 7), 32'(n) << 2, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("wrap_count", 32'(utype_count), 32'h1);

    // Reset while holding two entries
    cycle(1'b1, 32'h11111037, 32'h0000_0300, 1'b0);
    cycle(1'b1, 32'h22222037, 32'h0000_0304, 1'b0);
    chk("two_ready", 32'(bus.in_ready), 32'h0);
    apply_reset();
    cycle(1'b1, 32'h123452B7, 32'h0000_0400, 1'b1);
    chk("post_rst_imm", bus.imm20,  32'h1234_5000);
    chk("post_rst_pc",  bus.pc_out, 32'h0000_0400);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("post_rst_count", 32'(utype_count), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
